// File: rtl/spi_meas_pkg.sv
// Shared encodings and widths for the measurement SPI reader.
package spi_meas_pkg;

  localparam int WORD_W = 24;
  localparam int BYTE_W = 8;

  localparam logic [7:0] CMD_READ_MEAS = 8'h01;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_CMD      = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_CS_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

endpackage

// File: rtl/spi_meas_reader_sck_gen.sv
// SCK divider: down-counter reloads at terminal count; ticks alternate rise/fall
// while sck_en is high, otherwise SCK is parked low.
module spi_sck_gen #(
  parameter int CLK_DIV = 3
) (
  input  logic clk_12mhz,
  input  logic rst_sync,
  input  logic en,
  input  logic sck_en,
  output logic tick,
  output logic rise_tick,
  output logic fall_tick,
  output logic sck
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;

  assign tick      = en && (cnt_q == '0);
  assign rise_tick = tick && sck_en && !sck_q;
  assign fall_tick = tick && sck_en && sck_q;
  assign sck       = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en || tick) begin
      cnt_d = CNT_LOAD;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    if (!sck_en) begin
      sck_d = 1'b0;
    end else if (tick) begin
      sck_d = ~sck_q;
    end
  end

  always_ff @(posedge clk_12mhz) begin
    if (rst_sync) begin
      cnt_q <= CNT_LOAD;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_meas_reader.sv
// SPI mode-0 master: one command byte out, then n_words 24-bit words in
// (LSB byte first, MSB bit first within each byte).
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for start, CS high, busy low
// CS_SETUP  | CS low, SCK parked low for one half-period
// CMD       | 8 SCK periods shifting the command byte out
// DATA      | 8*WORD_BYTES*N SCK periods shifting MISO in
// CS_HOLD   | SCK low one half-period before CS rises
// GAP       | CS high for GAP_CYCLES, then back to IDLE
module spi_meas_reader
  import spi_meas_pkg::*;
#(
  parameter int CLK_DIV    = 3,
  parameter int WORD_BYTES = 3,
  parameter int GAP_CYCLES = 6
) (
  input  logic                clk_12mhz,
  input  logic                rst_sync,
  input  logic                start,
  input  logic [7:0]          cmd,
  input  logic [3:0]          n_words,
  output logic                spi_clk,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic                spi_cs,
  output logic                busy,
  output logic [WORD_W-1:0]   data_out,
  output logic                data_valid,
  output logic                done
);

  localparam int BC_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(WORD_BYTES - 1);
  localparam logic [GW-1:0]   GAP_LOAD  = GW'(GAP_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              dv_q, dv_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [6:0]        cmd_sh_q, cmd_sh_d;
  logic [6:0]        byte_sh_q, byte_sh_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [3:0]        word_cnt_q, word_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              miso_meta_q, miso_sync_q;
  logic [1:0]        rise_dly_q, rise_dly_d;

  logic              tick, rise_tick, fall_tick, sck;
  logic              div_en, sck_en, sample;
  logic [7:0]        byte_next;
  logic [WORD_W-1:0] word_next;

  assign div_en = (state_q != ST_IDLE);
  assign sck_en = (state_q == ST_CMD) || (state_q == ST_DATA);
  // Rising tick delayed to line up with the 2-FF synchronizer latency.
  assign sample = rise_dly_q[1];

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk_12mhz (clk_12mhz),
    .rst_sync  (rst_sync),
    .en        (div_en),
    .sck_en    (sck_en),
    .tick      (tick),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sck       (sck)
  );

  always_comb begin
    state_d    = state_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    dv_d       = 1'b0;
    data_out_d = data_out_q;
    acc_d      = acc_q;
    cmd_sh_d   = cmd_sh_q;
    byte_sh_d  = byte_sh_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rise_dly_d = {rise_dly_q[0], rise_tick && (state_q == ST_DATA)};
    byte_next  = {byte_sh_q, miso_sync_q};
    word_next  = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CS_SETUP;
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          mosi_d     = cmd[7];
          cmd_sh_d   = cmd[6:0];
          word_cnt_d = (n_words == 4'd0) ? 4'd1 : n_words;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
        end
      end
      ST_CS_SETUP: begin
        if (tick) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (fall_tick) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            mosi_d  = 1'b0;
            state_d = ST_DATA;
          end else begin
            mosi_d   = cmd_sh_q[6];
            cmd_sh_d = {cmd_sh_q[5:0], 1'b0};
          end
        end
      end
      ST_DATA: begin
        if (fall_tick) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q == BYTE_LAST) begin
              byte_cnt_d = '0;
              word_cnt_d = word_cnt_q - 4'd1;
              if (word_cnt_q == 4'd1) state_d = ST_CS_HOLD;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_CS_HOLD: begin
        if (tick) begin
          cs_d      = 1'b1;
          done_d    = 1'b1;
          gap_cnt_d = GAP_LOAD;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The sample point never trails the falling tick, so counters still name the bit.
    if (sample) begin
      byte_sh_d = byte_next[6:0];
      if (bit_cnt_q == 3'd7) begin
        word_next[byte_cnt_q*BYTE_W +: BYTE_W] = byte_next;
        acc_d = word_next;
        if (byte_cnt_q == BYTE_LAST) begin
          data_out_d = word_next;
          dv_d       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_12mhz) begin
    if (rst_sync) begin
      state_q     <= ST_IDLE;
      cs_q        <= 1'b1;
      busy_q      <= 1'b0;
      mosi_q      <= 1'b0;
      done_q      <= 1'b0;
      dv_q        <= 1'b0;
      data_out_q  <= '0;
      acc_q       <= '0;
      cmd_sh_q    <= '0;
      byte_sh_q   <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
      rise_dly_q  <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      busy_q      <= busy_d;
      mosi_q      <= mosi_d;
      done_q      <= done_d;
      dv_q        <= dv_d;
      data_out_q  <= data_out_d;
      acc_q       <= acc_d;
      cmd_sh_q    <= cmd_sh_d;
      byte_sh_q   <= byte_sh_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      miso_meta_q <= spi_miso;
      miso_sync_q <= miso_meta_q;
      rise_dly_q  <= rise_dly_d;
    end
  end

  assign spi_clk    = sck;
  assign spi_mosi   = mosi_q;
  assign spi_cs     = cs_q;
  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_valid = dv_q;
  assign done       = done_q;

endmodule

// File: tb/tb_spi_meas_reader.sv
// Directed bench: dut_a (CLK_DIV=3) talks to a byte-queue slave model,
// dut_b (CLK_DIV=2) is used for edge-timing measurements.
module tb_spi_meas_reader;
  import spi_meas_pkg::*;

  logic clk_12mhz = 1'b0;
  always #5 clk_12mhz = ~clk_12mhz;

  logic rst_sync;

  logic        a_start, a_sck, a_mosi, a_cs, a_busy, a_dv, a_done;
  logic        a_miso = 1'b0;
  logic [7:0]  a_cmd;
  logic [3:0]  a_n;
  logic [23:0] a_dout;

  logic        b_start, b_sck, b_mosi, b_cs, b_busy, b_dv, b_done;
  logic        b_miso;
  logic [7:0]  b_cmd;
  logic [3:0]  b_n;
  logic [23:0] b_dout;
  assign b_miso = 1'b1;

  spi_meas_reader #(.CLK_DIV(3), .WORD_BYTES(3), .GAP_CYCLES(6)) dut_a (
    .clk_12mhz(clk_12mhz), .rst_sync(rst_sync), .start(a_start), .cmd(a_cmd),
    .n_words(a_n), .spi_clk(a_sck), .spi_mosi(a_mosi), .spi_miso(a_miso),
    .spi_cs(a_cs), .busy(a_busy), .data_out(a_dout), .data_valid(a_dv), .done(a_done));

  spi_meas_reader #(.CLK_DIV(2), .WORD_BYTES(3), .GAP_CYCLES(6)) dut_b (
    .clk_12mhz(clk_12mhz), .rst_sync(rst_sync), .start(b_start), .cmd(b_cmd),
    .n_words(b_n), .spi_clk(b_sck), .spi_mosi(b_mosi), .spi_miso(b_miso),
    .spi_cs(b_cs), .busy(b_busy), .data_out(b_dout), .data_valid(b_dv), .done(b_done));

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model for dut_a: bytes returned after the command byte.
  logic [7:0]  slave_bytes [0:8];
  logic        a_sck_prev = 1'b0, a_cs_prev = 1'b1;
  int          a_rif = 0, a_rises = 0, a_cs_falls = 0, a_dv_cnt = 0, a_done_cnt = 0;
  int          a_data_ones = 0, a_bad = 0;
  logic [7:0]  a_mosi_cmd = 8'h00;
  logic [23:0] a_dv_q [$];

  function automatic logic slave_bit(input int idx);
    int d;
    if (idx < 8) return 1'b1;
    d = idx - 8;
    if ((d / 8) > 8) return 1'b0;
    return slave_bytes[d / 8][7 - (d % 8)];
  endfunction

  always @(posedge clk_12mhz) begin
    a_sck_prev <= a_sck;
    a_cs_prev  <= a_cs;
    if ((a_cs_prev != a_cs) && a_sck) a_bad <= a_bad + 1;
    if (a_cs && a_sck) a_bad <= a_bad + 1;
    if (a_cs_prev && !a_cs) begin
      a_rif      <= 0;
      a_miso     <= 1'b1;
      a_cs_falls <= a_cs_falls + 1;
    end else if (!a_cs) begin
      if (!a_sck_prev && a_sck) begin
        a_rises <= a_rises + 1;
        a_rif   <= a_rif + 1;
        if (a_rif < 8) a_mosi_cmd <= {a_mosi_cmd[6:0], a_mosi};
        else if (a_mosi) a_data_ones <= a_data_ones + 1;
      end
      if (a_sck_prev && !a_sck) a_miso <= slave_bit(a_rif);
    end
    if (a_dv) begin
      a_dv_cnt <= a_dv_cnt + 1;
      a_dv_q.push_back(a_dout);
    end
    if (a_done) a_done_cnt <= a_done_cnt + 1;
  end

  // Edge-time monitor for dut_b.
  int   cyc = 0;
  logic b_sck_prev = 1'b0, b_cs_prev = 1'b1, b_got_rise = 1'b0, b_got_fall = 1'b0;
  int   b_t_csf = 0, b_t_csr = 0, b_t_rise = 0, b_t_fall = 0, b_cs_high = 0;
  int   b_rises = 0, b_dv_cnt = 0, b_bad = 0;

  always @(posedge clk_12mhz) begin
    cyc        <= cyc + 1;
    b_sck_prev <= b_sck;
    b_cs_prev  <= b_cs;
    if ((b_cs_prev != b_cs) && b_sck) b_bad <= b_bad + 1;
    if (b_cs && b_sck) b_bad <= b_bad + 1;
    if (b_cs_prev && !b_cs) begin
      b_t_csf    <= cyc;
      b_cs_high  <= cyc - b_t_csr;
      b_got_rise <= 1'b0;
      b_got_fall <= 1'b0;
    end
    if (!b_cs_prev && b_cs) b_t_csr <= cyc;
    if (!b_sck_prev && b_sck) begin
      b_rises <= b_rises + 1;
      if (!b_got_rise) begin b_t_rise <= cyc; b_got_rise <= 1'b1; end
    end
    if (b_sck_prev && !b_sck && !b_got_fall) begin
      b_t_fall   <= cyc;
      b_got_fall <= 1'b1;
    end
    if (b_dv) b_dv_cnt <= b_dv_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Starts one frame and follows busy until it drops; always returns on a negedge.
  task automatic run_frame(input bit use_b, input logic [7:0] c, input logic [3:0] n,
                           output int busy_cyc, output int done_at, output bit tmo);
    busy_cyc = 0;
    done_at  = -1;
    tmo      = 1'b0;
    if (use_b) begin b_cmd = c; b_n = n; b_start = 1'b1; end
    else       begin a_cmd = c; a_n = n; a_start = 1'b1; end
    @(negedge clk_12mhz);
    a_start = 1'b0;
    b_start = 1'b0;
    while ((use_b ? b_busy : a_busy) && busy_cyc < 2000) begin
      if (use_b ? b_done : a_done) done_at = busy_cyc;
      busy_cyc++;
      @(negedge clk_12mhz);
    end
    if (busy_cyc >= 2000) tmo = 1'b1;
  endtask

  task automatic test_reset();
    rst_sync = 1'b1;
    a_start = 1'b0; a_cmd = 8'h00; a_n = 4'd0;
    b_start = 1'b0; b_cmd = 8'h00; b_n = 4'd0;
    repeat (3) @(negedge clk_12mhz);
    n_checks++; if (a_cs !== 1'b1)     begin n_fail++; $display("FAIL reset_cs: got %b exp 1", a_cs); end
    n_checks++; if (a_sck !== 1'b0)    begin n_fail++; $display("FAIL reset_sck: got %b exp 0", a_sck); end
    n_checks++; if (a_mosi !== 1'b0)   begin n_fail++; $display("FAIL reset_mosi: got %b exp 0", a_mosi); end
    n_checks++; if (a_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b exp 0", a_busy); end
    n_checks++; if (a_dv !== 1'b0)     begin n_fail++; $display("FAIL reset_dv: got %b exp 0", a_dv); end
    n_checks++; if (a_done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b exp 0", a_done); end
    n_checks++; if (a_dout !== 24'h0)  begin n_fail++; $display("FAIL reset_dout: got %h exp 000000", a_dout); end
    n_checks++; if (b_cs !== 1'b1)     begin n_fail++; $display("FAIL reset_b_cs: got %b exp 1", b_cs); end
    rst_sync = 1'b0;
    repeat (2) @(negedge clk_12mhz);
  endtask

  task automatic test_single_word();
    int bc, da, r0, v0, d0, c0;
    bit tmo;
    slave_bytes = '{8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    r0 = a_rises; v0 = a_dv_cnt; d0 = a_done_cnt; c0 = a_cs_falls;
    run_frame(1'b0, 8'hA5, 4'd1, bc, da, tmo);
    n_checks++; if (tmo !== 1'b0)            begin n_fail++; $display("FAIL single_timeout: busy never fell"); end
    n_checks++; if (a_mosi_cmd !== 8'hA5)    begin n_fail++; $display("FAIL single_mosi: got %h exp a5", a_mosi_cmd); end
    n_checks++; if (a_rises - r0 != 32)      begin n_fail++; $display("FAIL single_rises: got %0d exp 32", a_rises - r0); end
    n_checks++; if (a_dv_cnt - v0 != 1)      begin n_fail++; $display("FAIL single_dv_count: got %0d exp 1", a_dv_cnt - v0); end
    n_checks++; if (a_dout !== 24'h123456)   begin n_fail++; $display("FAIL single_data: got %h exp 123456", a_dout); end
    n_checks++; if (a_done_cnt - d0 != 1)    begin n_fail++; $display("FAIL single_done: got %0d exp 1", a_done_cnt - d0); end
    n_checks++; if (a_cs_falls - c0 != 1)    begin n_fail++; $display("FAIL single_cs_windows: got %0d exp 1", a_cs_falls - c0); end
    n_checks++; if (bc != 204)               begin n_fail++; $display("FAIL single_frame_len: got %0d exp 204", bc); end
    n_checks++; if (bc - da != 6)            begin n_fail++; $display("FAIL single_gap: got %0d exp 6", bc - da); end
  endtask

  task automatic test_multi_word();
    int bc, da, r0, v0, o0, c0;
    bit tmo;
    logic [23:0] got;
    logic [23:0] exp_w [0:2];
    exp_w = '{24'h000001, 24'hFFFFFF, 24'h800000};
    slave_bytes = '{8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h80};
    r0 = a_rises; v0 = a_dv_cnt; o0 = a_data_ones; c0 = a_cs_falls;
    run_frame(1'b0, 8'h96, 4'd3, bc, da, tmo);
    n_checks++; if (tmo !== 1'b0)            begin n_fail++; $display("FAIL multi_timeout: busy never fell"); end
    n_checks++; if (a_rises - r0 != 80)      begin n_fail++; $display("FAIL multi_rises: got %0d exp 80", a_rises - r0); end
    n_checks++; if (a_dv_cnt - v0 != 3)      begin n_fail++; $display("FAIL multi_dv_count: got %0d exp 3", a_dv_cnt - v0); end
    for (int i = 0; i < 3; i++) begin
      got = (a_dv_q.size() > v0 + i) ? a_dv_q[v0 + i] : 24'hxxxxxx;
      n_checks++; if (got !== exp_w[i]) begin n_fail++; $display("FAIL multi_word%0d: got %h exp %h", i, got, exp_w[i]); end
    end
    n_checks++; if (a_cs_falls - c0 != 1)    begin n_fail++; $display("FAIL multi_cs_windows: got %0d exp 1", a_cs_falls - c0); end
    n_checks++; if (a_data_ones - o0 != 0)   begin n_fail++; $display("FAIL multi_mosi_data: got %0d ones exp 0", a_data_ones - o0); end
    n_checks++; if (bc != 492)               begin n_fail++; $display("FAIL multi_frame_len: got %0d exp 492", bc); end
  endtask

  task automatic test_zero_words();
    int bc, da, r0, v0;
    bit tmo;
    slave_bytes = '{8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    r0 = a_rises; v0 = a_dv_cnt;
    run_frame(1'b0, CMD_READ_MEAS, 4'd0, bc, da, tmo);
    n_checks++; if (tmo !== 1'b0)            begin n_fail++; $display("FAIL zero_timeout: busy never fell"); end
    n_checks++; if (a_rises - r0 != 32)      begin n_fail++; $display("FAIL zero_rises: got %0d exp 32", a_rises - r0); end
    n_checks++; if (a_dv_cnt - v0 != 1)      begin n_fail++; $display("FAIL zero_dv_count: got %0d exp 1", a_dv_cnt - v0); end
    n_checks++; if (a_dout !== 24'hEFCDAB)   begin n_fail++; $display("FAIL zero_data: got %h exp efcdab", a_dout); end
    n_checks++; if (a_mosi_cmd !== 8'h01)    begin n_fail++; $display("FAIL zero_mosi: got %h exp 01", a_mosi_cmd); end
    n_checks++; if (bc != 204)               begin n_fail++; $display("FAIL zero_frame_len: got %0d exp 204", bc); end
  endtask

  task automatic test_start_while_busy();
    int k, v0, d0, c0;
    slave_bytes = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    v0 = a_dv_cnt; d0 = a_done_cnt; c0 = a_cs_falls;
    a_cmd = 8'h3C; a_n = 4'd1; a_start = 1'b1;
    @(negedge clk_12mhz);
    a_start = 1'b0;
    k = 0;
    while (a_busy && k < 2000) begin
      // 100 is mid-DATA; 203 is the last busy-high cycle, so busy falls on that edge.
      a_start = (k == 100) || (k == 203);
      k++;
      @(negedge clk_12mhz);
    end
    a_start = 1'b0;
    repeat (20) @(negedge clk_12mhz);
    n_checks++; if (k != 204)                begin n_fail++; $display("FAIL busy_frame_len: got %0d exp 204", k); end
    n_checks++; if (a_busy !== 1'b0)         begin n_fail++; $display("FAIL busy_restarted: busy %b exp 0", a_busy); end
    n_checks++; if (a_cs_falls - c0 != 1)    begin n_fail++; $display("FAIL busy_cs_windows: got %0d exp 1", a_cs_falls - c0); end
    n_checks++; if (a_done_cnt - d0 != 1)    begin n_fail++; $display("FAIL busy_done: got %0d exp 1", a_done_cnt - d0); end
    n_checks++; if (a_dv_cnt - v0 != 1)      begin n_fail++; $display("FAIL busy_dv_count: got %0d exp 1", a_dv_cnt - v0); end
    n_checks++; if (a_dout !== 24'h332211)   begin n_fail++; $display("FAIL busy_data: got %h exp 332211", a_dout); end
  endtask

  task automatic test_reset_mid_frame();
    int bc, da, r0, v0;
    bit tmo;
    slave_bytes = '{8'h77, 8'h66, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    v0 = a_dv_cnt;
    a_cmd = 8'hA5; a_n = 4'd1; a_start = 1'b1;
    @(negedge clk_12mhz);
    a_start = 1'b0;
    // Second data byte occupies cycles 99..146 of the frame.
    repeat (120) @(negedge clk_12mhz);
    rst_sync = 1'b1;
    @(negedge clk_12mhz);
    n_checks++; if (a_cs !== 1'b1)           begin n_fail++; $display("FAIL rstmid_cs: got %b exp 1", a_cs); end
    n_checks++; if (a_sck !== 1'b0)          begin n_fail++; $display("FAIL rstmid_sck: got %b exp 0", a_sck); end
    n_checks++; if (a_busy !== 1'b0)         begin n_fail++; $display("FAIL rstmid_busy: got %b exp 0", a_busy); end
    n_checks++; if (a_mosi !== 1'b0)         begin n_fail++; $display("FAIL rstmid_mosi: got %b exp 0", a_mosi); end
    rst_sync = 1'b0;
    repeat (250) @(negedge clk_12mhz);
    n_checks++; if (a_dv_cnt - v0 != 0)      begin n_fail++; $display("FAIL rstmid_dv: got %0d pulses exp 0", a_dv_cnt - v0); end
    r0 = a_rises; v0 = a_dv_cnt;
    run_frame(1'b0, 8'hA5, 4'd1, bc, da, tmo);
    n_checks++; if (tmo !== 1'b0)            begin n_fail++; $display("FAIL rstmid_timeout: busy never fell"); end
    n_checks++; if (a_rises - r0 != 32)      begin n_fail++; $display("FAIL rstmid_rises: got %0d exp 32", a_rises - r0); end
    n_checks++; if (a_dv_cnt - v0 != 1)      begin n_fail++; $display("FAIL rstmid_dv_after: got %0d exp 1", a_dv_cnt - v0); end
    n_checks++; if (a_dout !== 24'h556677)   begin n_fail++; $display("FAIL rstmid_data: got %h exp 556677", a_dout); end
  endtask

  task automatic test_timing();
    int bc1, bc2, da, r0, v0;
    bit tmo1, tmo2;
    r0 = b_rises; v0 = b_dv_cnt;
    run_frame(1'b1, 8'h5A, 4'd1, bc1, da, tmo1);
    run_frame(1'b1, 8'h5A, 4'd1, bc2, da, tmo2);
    repeat (3) @(negedge clk_12mhz);
    n_checks++; if (tmo1 || tmo2)                begin n_fail++; $display("FAIL timing_timeout: busy never fell"); end
    n_checks++; if (b_t_rise - b_t_csf != 4)     begin n_fail++; $display("FAIL timing_cs_to_rise: got %0d exp 4", b_t_rise - b_t_csf); end
    n_checks++; if (b_t_fall - b_t_rise != 2)    begin n_fail++; $display("FAIL timing_half_period: got %0d exp 2", b_t_fall - b_t_rise); end
    n_checks++; if (b_cs_high < 6)               begin n_fail++; $display("FAIL timing_cs_high: got %0d exp >=6", b_cs_high); end
    n_checks++; if (bc2 != 138)                  begin n_fail++; $display("FAIL timing_frame_len: got %0d exp 138", bc2); end
    n_checks++; if (b_rises - r0 != 64)          begin n_fail++; $display("FAIL timing_rises: got %0d exp 64", b_rises - r0); end
    n_checks++; if (b_dv_cnt - v0 != 2)          begin n_fail++; $display("FAIL timing_dv_count: got %0d exp 2", b_dv_cnt - v0); end
    n_checks++; if (b_dout !== 24'hFFFFFF)       begin n_fail++; $display("FAIL timing_data: got %h exp ffffff", b_dout); end
    n_checks++; if (b_bad != 0)                  begin n_fail++; $display("FAIL timing_sck_vs_cs: got %0d exp 0", b_bad); end
    n_checks++; if (a_bad != 0)                  begin n_fail++; $display("FAIL a_sck_vs_cs: got %0d exp 0", a_bad); end
  endtask

  initial begin
    @(negedge clk_12mhz);
    test_reset();
    test_single_word();
    test_multi_word();
    test_zero_words();
    test_start_while_busy();
    test_reset_mid_frame();
    test_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
